// File: rtl/axi_mem_pkg.sv
// Purpose : shared types for axi_mem_responder (FSM states, burst encodings, response codes, burst attributes).
// Latency : n/a (types and a pure helper function only).
// Backpr. : n/a.
// Config  : AXI_MEM_WRAP_BURST_EN enables WRAP burst support (wrap_len_ok is used only then).
package axi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RRESP = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width-independent part of the burst context; id/addr are added by the top,
  // whose widths are parameters.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       err;    // sticky: some beat of this write burst erred
  } burst_attr_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Purpose : next-beat address and per-beat error check, shared by the read and write paths.
// Latency : purely combinational.
// Backpr. : none; the caller decides when to advance.
// Ports   : addr_i/len_i/size_i/burst_i = current beat context; next_addr_o = following beat address;
//           err_o = current beat is illegal (size > 2, bad burst type, address >= MEM_SIZE).
// Config  : AXI_MEM_WRAP_BURST_EN defined -> WRAP bursts with len 1/3/7/15 are legal and wrap;
//           undefined -> WRAP is an illegal burst type.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_SIZE       = 32768
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]                len_i,
  input  logic [2:0]                size_i,
  input  logic [1:0]                burst_i,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
  output logic                      err_o
);

  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT = AXI_ADDR_WIDTH'(MEM_SIZE);

  logic [AXI_ADDR_WIDTH-1:0] incr_addr;
  logic                      burst_ok;

`ifdef AXI_MEM_WRAP_BURST_EN
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    // Natural modulo-2^AXI_ADDR_WIDTH wrap of the adder; no 4 KB check.
    incr_addr   = addr_i + (AXI_ADDR_WIDTH'(1) << size_i);
    next_addr_o = incr_addr;
    burst_ok    = (burst_i == BURST_INCR);
`ifdef AXI_MEM_WRAP_BURST_EN
    // Window is (len+1)<<size bytes; the low bits advance, the high bits stay.
    wrap_mask = ((AXI_ADDR_WIDTH'(len_i) + AXI_ADDR_WIDTH'(1)) << size_i) - AXI_ADDR_WIDTH'(1);
    if (burst_i == BURST_WRAP) begin
      burst_ok    = wrap_len_ok(len_i);
      next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
    end
`endif
    err_o = (size_i > 3'd2) || !burst_ok || (addr_i >= MEM_LIMIT);
  end

endmodule

// File: rtl/axi_mem_responder.sv
// Purpose : AXI4 slave terminating one master port onto a single-port word SRAM, one burst at a time.
// Latency : write beat hits memory in its W handshake cycle, B one cycle after last W;
//           read beat: req +1, data captured +2, R valid +3 after AR/previous R handshake.
// Backpr. : AW/AR round-robin in IDLE only; W taken every cycle in WDATA; B/R held until ready.
// Ports   : clk_i/rst_i (async active-high); AXI AW/W/B/AR/R slave channels;
//           mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o/mem_rdata_i SRAM side.
// Config  : AXI_MEM_WRAP_BURST_EN enables WRAP bursts (see axi_mem_addr_gen).
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int MEM_SIZE       = 32768,
  parameter int MEM_ADDR_WIDTH = $clog2(MEM_SIZE) - 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // AW
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  // W
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  // B
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  // AR
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  // R
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  // SRAM
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i
);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    burst_attr_t               attr;
  } ctx_t;

  state_t                    state_q;
  ctx_t                      ctx_q;
  logic [7:0]                beat_q;
  logic                      prio_w_q;   // write wins a tie when set
  logic                      rd_err_q;   // error flag of the read beat in flight
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]                r_resp_q;
  logic                      r_last_q;

  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      beat_err;
  logic                      last_beat;
  logic                      wr_access;
  logic                      rd_access;

  axi_mem_addr_gen #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MEM_SIZE       (MEM_SIZE)
  ) u_addr_gen (
    .addr_i      (ctx_q.addr),
    .len_i       (ctx_q.attr.len),
    .size_i      (ctx_q.attr.size),
    .burst_i     (ctx_q.attr.burst),
    .next_addr_o (next_addr),
    .err_o       (beat_err)
  );

  assign last_beat = (beat_q == ctx_q.attr.len);

  always_comb begin
    // Ready is gated by reset so every output reads 0 while rst_i is high.
    aw_ready_o = !rst_i && (state_q == ST_IDLE) && aw_valid_i && (!ar_valid_i || prio_w_q);
    ar_ready_o = !rst_i && (state_q == ST_IDLE) && ar_valid_i && (!aw_valid_i || !prio_w_q);
    w_ready_o  = (state_q == ST_WDATA);

    // Writes go to memory combinationally in the W handshake cycle.
    wr_access  = w_ready_o && w_valid_i && !beat_err;
    rd_access  = (state_q == ST_RREQ) && !beat_err;

    mem_req_o   = wr_access || rd_access;
    mem_we_o    = wr_access;
    mem_be_o    = wr_access ? w_strb_i : (rd_access ? 4'hF : 4'h0);
    mem_wdata_o = wr_access ? w_data_i : '0;
    mem_addr_o  = mem_req_o ? ctx_q.addr[MEM_ADDR_WIDTH+1:2] : '0;

    b_valid_o = (state_q == ST_WRESP);
    b_id_o    = ctx_q.id;
    b_resp_o  = ctx_q.attr.err ? RESP_SLVERR : RESP_OKAY;

    r_valid_o = (state_q == ST_RRESP);
    r_data_o  = r_data_q;
    r_id_o    = ctx_q.id;
    r_resp_o  = r_resp_q;
    r_last_o  = r_last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ctx_q    <= '0;
      beat_q   <= '0;
      prio_w_q <= 1'b1;
      rd_err_q <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
      r_last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aw_ready_o) begin
            ctx_q.id   <= aw_id_i;
            ctx_q.addr <= aw_addr_i;
            ctx_q.attr <= '{len: aw_len_i, size: aw_size_i, burst: aw_burst_i, err: 1'b0};
            beat_q     <= '0;
            prio_w_q   <= 1'b0;
            state_q    <= ST_WDATA;
          end else if (ar_ready_o) begin
            ctx_q.id   <= ar_id_i;
            ctx_q.addr <= ar_addr_i;
            ctx_q.attr <= '{len: ar_len_i, size: ar_size_i, burst: ar_burst_i, err: 1'b0};
            beat_q     <= '0;
            prio_w_q   <= 1'b1;
            state_q    <= ST_RREQ;
          end
        end
        ST_WDATA: begin
          if (w_valid_i) begin
            // A misplaced WLAST poisons the response but the burst length
            // is still taken from AWLEN.
            ctx_q.attr.err <= ctx_q.attr.err || beat_err || (w_last_i != last_beat);
            ctx_q.addr     <= next_addr;
            if (last_beat) begin
              state_q <= ST_WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        ST_WRESP: begin
          if (b_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RREQ: begin
          rd_err_q <= beat_err;
          state_q  <= ST_RWAIT;
        end
        ST_RWAIT: begin
          r_data_q <= rd_err_q ? '0 : mem_rdata_i;
          r_resp_q <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
          r_last_q <= last_beat;
          state_q  <= ST_RRESP;
        end
        ST_RRESP: begin
          if (r_ready_i) begin
            r_last_q <= 1'b0;
            if (last_beat) begin
              state_q <= ST_IDLE;
            end else begin
              beat_q     <= beat_q + 8'd1;
              ctx_q.addr <= next_addr;
              state_q    <= ST_RREQ;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Purpose : directed self-checking bench for axi_mem_responder with a behavioural SRAM.
// Latency : n/a.
// Backpr. : drives r_ready_i/b_ready_i low and high to exercise stalls.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic [5:0]  aw_id_i;
  logic        w_valid_i, w_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [5:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic [5:0]  ar_id_i;
  logic        r_valid_o, r_ready_i;
  logic [31:0] r_data_o;
  logic [5:0]  r_id_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: read data one cycle after the request; preload port for setup.
  logic [31:0] mem [0:8191];
  logic        pl_we = 1'b0;
  logic [12:0] pl_addr;
  logic [31:0] pl_dat;
  always @(posedge clk) begin
    if (mem_req_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
    if (mem_req_o && mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    if (pl_we) mem[pl_addr] <= pl_dat;
  end

  // Log of every memory request seen.
  int          lg_cyc[$];
  logic [12:0] lg_addr[$];
  logic        lg_we[$];
  logic [31:0] lg_wd[$];
  logic [3:0]  lg_be[$];
  always @(negedge clk) begin
    if (mem_req_o) begin
      lg_cyc.push_back(cyc);
      lg_addr.push_back(mem_addr_o);
      lg_we.push_back(mem_we_o);
      lg_wd.push_back(mem_wdata_o);
      lg_be.push_back(mem_be_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  int aw_cyc, ar_cyc, w_cyc, b_cyc;

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    pl_addr = a; pl_dat = d; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [5:0] id);
    logic got = 1'b0;
    aw_addr_i = a; aw_len_i = l; aw_size_i = s; aw_burst_i = bt; aw_id_i = id; aw_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = aw_ready_o;
    end
    aw_cyc = cyc;
    check("aw_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [5:0] id);
    logic got = 1'b0;
    ar_addr_i = a; ar_len_i = l; ar_size_i = s; ar_burst_i = bt; ar_id_i = id; ar_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = ar_ready_o;
    end
    ar_cyc = cyc;
    check("ar_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic lst);
    logic got = 1'b0;
    w_data_i = d; w_strb_i = st; w_last_i = lst; w_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = w_ready_o;
    end
    w_cyc = cyc;
    check("w_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    w_valid_i = 1'b0;
  endtask

  task automatic wait_b(output logic [5:0] id, output logic [1:0] rsp);
    logic got = 1'b0;
    b_ready_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = b_valid_o;
    end
    b_cyc = cyc; id = b_id_o; rsp = b_resp_o;
    check("b_valid_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    b_ready_i = 1'b0;
  endtask

  logic [31:0] rd_dat[$];
  logic [1:0]  rd_rsp[$];
  logic        rd_lst[$];
  logic [5:0]  rd_id[$];
  int          rd_cyc[$];

  // Collects n R beats; the caller holds r_ready_i high.
  task automatic collect_r(input int n);
    int got = 0;
    rd_dat.delete(); rd_rsp.delete(); rd_lst.delete(); rd_id.delete(); rd_cyc.delete();
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge clk);
      if (r_valid_o && r_ready_i) begin
        rd_dat.push_back(r_data_o); rd_rsp.push_back(r_resp_o); rd_lst.push_back(r_last_o);
        rd_id.push_back(r_id_o); rd_cyc.push_back(cyc);
        got++;
      end
    end
    check("r_beat_count", 64'(got), 64'(n));
    @(posedge clk); #1;
  endtask

  logic [5:0]  bid;
  logic [1:0]  brsp;
  int          n0;
  logic [31:0] d0;
  logic        l0, stable;
  logic        got_r;

  initial begin
    rst_i = 1'b1;
    aw_valid_i = 1'b1; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_id_i = '0;
    w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; b_ready_i = 1'b0;
    ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0; ar_id_i = '0;
    r_ready_i = 1'b0;

    // ---- reset state (AW valid held high to show ready stays low) ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", 64'(aw_ready_o), 64'd0);
    check("rst_ctrl", 64'({b_valid_o, r_valid_o, w_ready_o, mem_req_o, mem_we_o, r_last_o, ar_ready_o}), 64'd0);
    check("rst_data", {r_data_o, mem_wdata_o}, 64'd0);
    aw_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 4; i++) preload(13'(8 + i), 32'(i + 1));
    for (int i = 0; i < 4; i++) preload(13'(i), 32'hA0 + 32'(i));

    // ---- single write ----
    n0 = lg_cyc.size();
    send_aw(32'h10, 8'd0, 3'd2, 2'd1, 6'd5);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    check("wr1_w_cycle", 64'(w_cyc - aw_cyc), 64'd1);
    wait_b(bid, brsp);
    check("wr1_b_cycle", 64'(b_cyc - w_cyc), 64'd1);
    check("wr1_b_id", 64'(bid), 64'd5);
    check("wr1_b_resp", 64'(brsp), 64'd0);
    check("wr1_nreq", 64'(lg_cyc.size() - n0), 64'd1);
    check("wr1_mem", {19'd0, lg_we[n0], lg_addr[n0], lg_wd[n0]}, {19'd0, 1'b1, 13'd4, 32'hDEADBEEF});
    check("wr1_be", 64'(lg_be[n0]), 64'hF);
    check("wr1_req_cycle", 64'(lg_cyc[n0] - w_cyc), 64'd0);

    // ---- INCR read of 4 beats ----
    n0 = lg_cyc.size();
    r_ready_i = 1'b1;
    send_ar(32'h20, 8'd3, 3'd2, 2'd1, 6'd7);
    collect_r(4);
    r_ready_i = 1'b0;
    for (int i = 0; i < rd_dat.size(); i++) begin
      check("rd_data", 64'(rd_dat[i]), 64'(i + 1));
      check("rd_last", 64'(rd_lst[i]), 64'(i == 3));
      check("rd_resp", 64'(rd_rsp[i]), 64'd0);
      check("rd_id", 64'(rd_id[i]), 64'd7);
      if (i > 0) check("rd_spacing", 64'(rd_cyc[i] - rd_cyc[i-1]), 64'd3);
    end
    if (rd_cyc.size() > 0) check("rd_first_latency", 64'(rd_cyc[0] - ar_cyc), 64'd3);
    check("rd_nreq", 64'(lg_cyc.size() - n0), 64'd4);
    if (lg_cyc.size() > n0) begin
      check("rd_req_cycle", 64'(lg_cyc[n0] - ar_cyc), 64'd1);
      check("rd_req_addr0", 64'(lg_addr[n0]), 64'd8);
    end

    // ---- arbitration straight after reset ----
    rst_i = 1'b1; #1; rst_i = 1'b0;
    @(posedge clk); #1;
    aw_addr_i = 32'h40; aw_len_i = 8'd0; aw_size_i = 3'd2; aw_burst_i = 2'd1; aw_id_i = 6'd1; aw_valid_i = 1'b1;
    ar_addr_i = 32'h20; ar_len_i = 8'd0; ar_size_i = 3'd2; ar_burst_i = 2'd1; ar_id_i = 6'd2; ar_valid_i = 1'b1;
    @(negedge clk);
    check("arb1_aw_ready", 64'(aw_ready_o), 64'd1);
    check("arb1_ar_ready", 64'(ar_ready_o), 64'd0);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    send_w(32'h11112222, 4'hF, 1'b1);
    wait_b(bid, brsp);
    check("arb1_b_id", 64'(bid), 64'd1);
    aw_addr_i = 32'h44; aw_id_i = 6'd3; aw_valid_i = 1'b1;
    @(negedge clk);
    check("arb2_ar_ready", 64'(ar_ready_o), 64'd1);
    check("arb2_aw_ready", 64'(aw_ready_o), 64'd0);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b1;
    collect_r(1);
    r_ready_i  = 1'b0;
    if (rd_dat.size() > 0) begin
      check("arb2_r_data", 64'(rd_dat[0]), 64'd1);
      check("arb2_r_id", 64'(rd_id[0]), 64'd2);
    end
    @(negedge clk);
    check("arb3_aw_ready", 64'(aw_ready_o), 64'd1);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    send_w(32'h33334444, 4'hF, 1'b1);
    wait_b(bid, brsp);
    check("arb3_b", {56'd0, bid, brsp}, {56'd0, 6'd3, 2'b00});

    // ---- out-of-range write ----
    n0 = lg_cyc.size();
    send_aw(32'h8000, 8'd1, 3'd2, 2'd1, 6'd9);
    send_w(32'h0, 4'hF, 1'b0);
    send_w(32'h0, 4'hF, 1'b1);
    wait_b(bid, brsp);
    check("oor_b_resp", 64'(brsp), 64'd2);
    check("oor_b_id", 64'(bid), 64'd9);
    check("oor_nreq", 64'(lg_cyc.size() - n0), 64'd0);

    // ---- R backpressure ----
    r_ready_i = 1'b0;
    send_ar(32'h20, 8'd1, 3'd2, 2'd1, 6'd4);
    got_r = 1'b0;
    for (int i = 0; i < 50 && !got_r; i++) begin
      @(negedge clk);
      got_r = r_valid_o;
    end
    check("bp_r_valid", 64'(got_r), 64'd1);
    d0 = r_data_o; l0 = r_last_o; n0 = lg_cyc.size();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!r_valid_o || r_data_o !== d0) stable = 1'b0;
    end
    #1;
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_data0", 64'(d0), 64'd1);
    check("bp_last0", 64'(l0), 64'd0);
    check("bp_no_req", 64'(lg_cyc.size() - n0), 64'd0);
    @(posedge clk); #1;
    r_ready_i = 1'b1;
    @(posedge clk); #1;
    collect_r(1);
    r_ready_i = 1'b0;
    if (rd_dat.size() > 0) begin
      check("bp_data1", 64'(rd_dat[0]), 64'd2);
      check("bp_last1", 64'(rd_lst[0]), 64'd1);
    end
    check("bp_nreq_after", 64'(lg_cyc.size() - n0), 64'd1);

    // ---- WRAP read ----
    n0 = lg_cyc.size();
    r_ready_i = 1'b1;
    send_ar(32'h0C, 8'd3, 3'd2, 2'd2, 6'd6);
    collect_r(4);
    r_ready_i = 1'b0;
`ifdef AXI_MEM_WRAP_BURST_EN
    check("wrap_nreq", 64'(lg_cyc.size() - n0), 64'd4);
    for (int i = 0; i < rd_dat.size(); i++) begin
      check("wrap_data", 64'(rd_dat[i]), 64'(32'hA0 + 32'((i + 3) % 4)));
      check("wrap_resp", 64'(rd_rsp[i]), 64'd0);
      check("wrap_last", 64'(rd_lst[i]), 64'(i == 3));
      if (lg_cyc.size() > n0 + i) check("wrap_addr", 64'(lg_addr[n0 + i]), 64'((i + 3) % 4));
    end
`else
    check("wrap_nreq", 64'(lg_cyc.size() - n0), 64'd0);
    for (int i = 0; i < rd_dat.size(); i++) begin
      check("wrap_data", 64'(rd_dat[i]), 64'd0);
      check("wrap_resp", 64'(rd_rsp[i]), 64'd2);
      check("wrap_last", 64'(rd_lst[i]), 64'(i == 3));
    end
`endif

    // ---- reset mid-burst ----
    send_aw(32'h80, 8'd3, 3'd2, 2'd1, 6'd3);
    send_w(32'h55, 4'hF, 1'b0);
    w_data_i = 32'h66; w_strb_i = 4'hF; w_last_i = 1'b0; w_valid_i = 1'b1;
    #2;
    check("mid_pre_req", 64'(mem_req_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_ctrl", 64'({mem_req_o, mem_we_o, w_ready_o, b_valid_o, r_valid_o, aw_ready_o, ar_ready_o, r_last_o}), 64'd0);
    check("mid_rst_mem", {19'd0, mem_addr_o, mem_wdata_o}, 64'd0);
    check("mid_rst_be", 64'(mem_be_o), 64'd0);
    w_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    send_aw(32'h84, 8'd0, 3'd2, 2'd1, 6'd3);
    send_w(32'h77778888, 4'hF, 1'b1);
    wait_b(bid, brsp);
    check("post_rst_b", {56'd0, bid, brsp}, {56'd0, 6'd3, 2'b00});
    r_ready_i = 1'b1;
    send_ar(32'h80, 8'd1, 3'd2, 2'd1, 6'd8);
    collect_r(2);
    r_ready_i = 1'b0;
    if (rd_dat.size() == 2) begin
      check("post_rst_rd0", 64'(rd_dat[0]), 64'h55);
      check("post_rst_rd1", 64'(rd_dat[1]), 64'h77778888);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
